// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time in sys_clk cycles; valid 3 clks after closing rise is sampled, no backpressure.
// Optional 4-period averaging when PWM_CAPTURE_AVG_EN is defined.
module pwm_capture #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 60_000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WAIT_RISE, HIGH, LOW, STUCK} state_t;

  state_t           state, state_nxt;
  logic             m0, m1, m2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] high_lat, high_lat_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             valid_nxt, timeout_nxt, stuck_nxt;
  logic             rise, fall, cnt_sat, stuck_hit, take_timeout, close_per;

`ifdef PWM_CAPTURE_AVG_EN
  logic [CNT_W+1:0] psum, psum_nxt, psum_add;
  logic [CNT_W+1:0] hsum, hsum_nxt, hsum_add;
  logic [1:0]       nper, nper_nxt;
`endif

  assign rise      = m1 & ~m2;
  assign fall      = ~m1 & m2;
  assign cnt_sat   = (cnt == TO_VAL);
  // An edge in the saturation cycle wins over the timeout.
  assign stuck_hit = cnt_sat & ~rise & ~fall;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_lat_nxt = high_lat;
    period_nxt   = period_cnt;
    high_nxt     = high_cnt;
    valid_nxt    = 1'b0;
    timeout_nxt  = timeout;
    stuck_nxt    = stuck_level;
    take_timeout = 1'b0;
    close_per    = 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
    psum_nxt = psum;
    hsum_nxt = hsum;
    nper_nxt = nper;
    psum_add = psum + {2'b00, cnt};
    hsum_add = hsum + {2'b00, high_lat};
`endif
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
`ifdef PWM_CAPTURE_AVG_EN
      psum_nxt = '0;
      hsum_nxt = '0;
      nper_nxt = '0;
`endif
    end else begin
      if (rise)
        cnt_nxt = CNT_W'(1);
      else if (!cnt_sat)
        cnt_nxt = cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise)           state_nxt = HIGH;
          else if (stuck_hit) take_timeout = 1'b1;
        end
        HIGH: begin
          if (fall) begin
            high_lat_nxt = cnt;
            state_nxt    = LOW;
          end else if (stuck_hit) begin
            take_timeout = 1'b1;
          end
        end
        LOW: begin
          if (rise)           close_per = 1'b1;
          else if (stuck_hit) take_timeout = 1'b1;
        end
        STUCK: begin
          if (rise) state_nxt = HIGH;
        end
        default: state_nxt = IDLE;
      endcase

      if (take_timeout) begin
        timeout_nxt = 1'b1;
        stuck_nxt   = m1;
        period_nxt  = '0;
        high_nxt    = '0;
        valid_nxt   = 1'b1;
        state_nxt   = STUCK;
`ifdef PWM_CAPTURE_AVG_EN
        psum_nxt = '0;
        hsum_nxt = '0;
        nper_nxt = '0;
`endif
      end

      if (close_per) begin
        state_nxt = HIGH;
`ifdef PWM_CAPTURE_AVG_EN
        if (nper == 2'd3) begin
          period_nxt  = psum_add[CNT_W+1:2];
          high_nxt    = hsum_add[CNT_W+1:2];
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          psum_nxt    = '0;
          hsum_nxt    = '0;
          nper_nxt    = '0;
        end else begin
          psum_nxt = psum_add;
          hsum_nxt = hsum_add;
          nper_nxt = nper + 2'd1;
        end
`else
        period_nxt  = cnt;
        high_nxt    = high_lat;
        valid_nxt   = 1'b1;
        timeout_nxt = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      m0          <= 1'b0;
      m1          <= 1'b0;
      m2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      high_lat    <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
      psum        <= '0;
      hsum        <= '0;
      nper        <= '0;
`endif
    end else begin
      m0          <= pwm_in;
      m1          <= m0;
      m2          <= m1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      high_lat    <= high_lat_nxt;
      period_cnt  <= period_nxt;
      high_cnt    <= high_nxt;
      valid       <= valid_nxt;
      timeout     <= timeout_nxt;
      stuck_level <= stuck_nxt;
`ifdef PWM_CAPTURE_AVG_EN
      psum        <= psum_nxt;
      hsum        <= hsum_nxt;
      nper        <= nper_nxt;
`endif
    end
  end

endmodule
